// File: rtl/qcw_phase_ramp.sv
// qcw_phase_ramp
// Turns a single start pulse into a programmed per-cycle phase ramp for the
// QCW bridge PLL. The phase walks from cfg_phase_start toward cfg_phase_end in
// cfg_step increments. Each step is taken after cfg_dwell resonant cycles.
// The phase then holds until the PLL ends the burst. An over-current halt
// forces the phase to zero until done arrives.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   start                single-cycle pulse, accepted only in idle
//   halt                 over-current abort (level or pulse)
//   cycle_finished       once-per-resonant-cycle pulse from the PLL
//   done                 burst-end pulse from the PLL
//   cfg_phase_start/end  ramp endpoints, latched at start
//   cfg_step             step magnitude, latched at start
//   cfg_dwell            resonant cycles per step (0 acts as 1), latched at start
//   phase_shift          registered phase command to the PLL
//   busy                 high while a burst is active or halted
//   ramp_done            single-cycle pulse on return to idle
//   halted               sticky abort flag, cleared by the next accepted start
module qcw_phase_ramp #(
    parameter int unsigned PHASE_W = 8,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               halt,
    input  logic               cycle_finished,
    input  logic               done,
    input  logic [PHASE_W-1:0] cfg_phase_start,
    input  logic [PHASE_W-1:0] cfg_phase_end,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [PHASE_W-1:0] phase_shift,
    output logic               busy,
    output logic               ramp_done,
    output logic               halted
);

    typedef enum logic [1:0] {StIdle, StRamp, StHold, StHalted} state_e;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [PHASE_W-1:0] end_q, end_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               up_q, up_d;
    logic               halted_q, halted_d;
    logic               ramp_done_q, ramp_done_d;
    logic               busy_q, busy_d;

    // One-step-toward-end arithmetic, one bit wider so neither direction wraps.
    logic [PHASE_W:0]   ph_ext, step_ext, end_ext, sum, diff;
    logic [PHASE_W-1:0] phase_next;
    logic [DWELL_W:0]   cnt_inc, dwell_eff;

    always_comb begin
        ph_ext   = {1'b0, phase_q};
        step_ext = {1'b0, step_q};
        end_ext  = {1'b0, end_q};
        sum      = ph_ext + step_ext;
        diff     = ph_ext - step_ext;
        if (up_q) begin
            phase_next = (sum >= end_ext) ? end_q : sum[PHASE_W-1:0];
        end else begin
            phase_next = ((phase_q < step_q) || (diff <= end_ext)) ? end_q : diff[PHASE_W-1:0];
        end
        cnt_inc   = {1'b0, cnt_q} + (DWELL_W+1)'(1);
        dwell_eff = (dwell_q == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell_q};
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        end_d       = end_q;
        dwell_d     = dwell_q;
        up_d        = up_q;
        halted_d    = halted_q;
        ramp_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                cnt_d   = '0;
                if (start) begin
                    step_d   = cfg_step;
                    end_d    = cfg_phase_end;
                    dwell_d  = cfg_dwell;
                    up_d     = (cfg_phase_end > cfg_phase_start);
                    phase_d  = cfg_phase_start;
                    halted_d = 1'b0;
                    if ((cfg_step == '0) || (cfg_phase_start == cfg_phase_end)) begin
                        state_d = StHold;
                    end else begin
                        state_d = StRamp;
                    end
                end
            end
            StRamp, StHold: begin
                if (done) begin
                    state_d     = StIdle;
                    phase_d     = '0;
                    cnt_d       = '0;
                    ramp_done_d = 1'b1;
                    if (halt) halted_d = 1'b1;
                end else if (halt) begin
                    state_d  = StHalted;
                    phase_d  = '0;
                    halted_d = 1'b1;
                end else if (cycle_finished && (state_q == StRamp)) begin
                    if (cnt_inc == dwell_eff) begin
                        cnt_d   = '0;
                        phase_d = phase_next;
                        if (phase_next == end_q) state_d = StHold;
                    end else begin
                        cnt_d = cnt_inc[DWELL_W-1:0];
                    end
                end
            end
            StHalted: begin
                phase_d = '0;
                if (done) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    ramp_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            cnt_q       <= '0;
            step_q      <= '0;
            end_q       <= '0;
            dwell_q     <= '0;
            up_q        <= 1'b0;
            halted_q    <= 1'b0;
            ramp_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            end_q       <= end_d;
            dwell_q     <= dwell_d;
            up_q        <= up_d;
            halted_q    <= halted_d;
            ramp_done_q <= ramp_done_d;
            busy_q      <= busy_d;
        end
    end

    assign phase_shift = phase_q;
    assign busy        = busy_q;
    assign ramp_done   = ramp_done_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_qcw_phase_ramp.sv
// Directed bench for qcw_phase_ramp: ramps, saturation, halt, coincident
// events, degenerate configs and asynchronous reset.
module tb_qcw_phase_ramp;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       cycle_finished = 1'b0;
    logic       done = 1'b0;
    logic [7:0] cfg_phase_start = '0;
    logic [7:0] cfg_phase_end = '0;
    logic [7:0] cfg_step = '0;
    logic [7:0] cfg_dwell = '0;
    logic [7:0] phase_shift;
    logic       busy;
    logic       ramp_done;
    logic       halted;

    int n_tests = 0;
    int n_fail  = 0;

    qcw_phase_ramp #(
        .PHASE_W(8),
        .DWELL_W(8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .halt           (halt),
        .cycle_finished (cycle_finished),
        .done           (done),
        .cfg_phase_start(cfg_phase_start),
        .cfg_phase_end  (cfg_phase_end),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .phase_shift    (phase_shift),
        .busy           (busy),
        .ramp_done      (ramp_done),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st,
                            input logic [7:0] dw);
        cfg_phase_start = s;
        cfg_phase_end   = e;
        cfg_step        = st;
        cfg_dwell       = dw;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cyc();
        cycle_finished = 1'b1;
        tick();
        cycle_finished = 1'b0;
    endtask

    task automatic do_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        check_eq("rst_phase", phase_shift, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ramp_done", ramp_done, 0);
        check_eq("rst_halted", halted, 0);
        reset_n = 1'b1;
        tick();

        // Up ramp 10 -> 40, step 10, dwell 2
        do_start(8'd10, 8'd40, 8'd10, 8'd2);
        check_eq("up_start_phase", phase_shift, 10);
        check_eq("up_start_busy", busy, 1);
        cyc(); check_eq("up_p1", phase_shift, 10);
        cyc(); check_eq("up_p2", phase_shift, 20);
        cyc(); check_eq("up_p3", phase_shift, 20);
        cyc(); check_eq("up_p4", phase_shift, 30);
        cyc(); check_eq("up_p5", phase_shift, 30);
        cyc(); check_eq("up_p6", phase_shift, 40);
        cyc(); check_eq("up_p7_hold", phase_shift, 40);
        cyc(); check_eq("up_p8_hold", phase_shift, 40);
        do_done();
        check_eq("up_done_phase", phase_shift, 0);
        check_eq("up_done_busy", busy, 0);
        check_eq("up_done_pulse", ramp_done, 1);
        tick();
        check_eq("up_done_pulse_end", ramp_done, 0);

        // Saturation near the top of the range, dwell 0 acts as 1
        do_start(8'd250, 8'd255, 8'd8, 8'd0);
        check_eq("sat_start", phase_shift, 250);
        cyc(); check_eq("sat_p1", phase_shift, 255);
        cyc(); check_eq("sat_p2_nowrap", phase_shift, 255);
        do_done();

        // Down ramp 5 -> 0, step 3
        do_start(8'd5, 8'd0, 8'd3, 8'd1);
        check_eq("dn_start", phase_shift, 5);
        cyc(); check_eq("dn_p1", phase_shift, 2);
        cyc(); check_eq("dn_p2", phase_shift, 0);
        cyc(); check_eq("dn_p3_hold", phase_shift, 0);
        check_eq("dn_busy", busy, 1);
        do_done();

        // Halt mid-ramp
        do_start(8'd10, 8'd40, 8'd10, 8'd1);
        cyc(); check_eq("halt_pre", phase_shift, 20);
        halt = 1'b1; tick(); halt = 1'b0;
        check_eq("halt_phase", phase_shift, 0);
        check_eq("halt_flag", halted, 1);
        check_eq("halt_busy", busy, 1);
        cyc(); check_eq("halt_cyc_ignored", phase_shift, 0);
        do_done();
        check_eq("halt_done_busy", busy, 0);
        check_eq("halt_done_pulse", ramp_done, 1);
        check_eq("halt_done_sticky", halted, 1);
        tick();
        check_eq("halt_idle_sticky", halted, 1);

        // done + cycle_finished together: no step, back to idle
        do_start(8'd10, 8'd40, 8'd10, 8'd1);
        check_eq("halt_cleared", halted, 0);
        cyc(); check_eq("dc_pre", phase_shift, 20);
        done = 1'b1; cycle_finished = 1'b1; tick(); done = 1'b0; cycle_finished = 1'b0;
        check_eq("dc_phase", phase_shift, 0);
        check_eq("dc_busy", busy, 0);
        check_eq("dc_pulse", ramp_done, 1);

        // done + halt together: idle with halted set
        do_start(8'd10, 8'd40, 8'd10, 8'd1);
        done = 1'b1; halt = 1'b1; tick(); done = 1'b0; halt = 1'b0;
        check_eq("dh_busy", busy, 0);
        check_eq("dh_halted", halted, 1);
        check_eq("dh_pulse", ramp_done, 1);

        // start while busy ignored; cfg changes mid-burst have no effect
        do_start(8'd10, 8'd40, 8'd10, 8'd1);
        cyc(); check_eq("sb_pre", phase_shift, 20);
        do_start(8'd100, 8'd200, 8'd50, 8'd3);
        check_eq("sb_phase_kept", phase_shift, 20);
        check_eq("sb_busy", busy, 1);
        cyc(); check_eq("sb_old_step", phase_shift, 30);
        cyc(); check_eq("sb_old_end", phase_shift, 40);
        cyc(); check_eq("sb_hold", phase_shift, 40);
        do_done();

        // Degenerate configs
        do_start(8'd33, 8'd90, 8'd0, 8'd1);
        check_eq("step0_start", phase_shift, 33);
        cyc(); check_eq("step0_hold", phase_shift, 33);
        do_done();
        do_start(8'd77, 8'd77, 8'd5, 8'd1);
        check_eq("eq_start", phase_shift, 77);
        cyc(); check_eq("eq_hold", phase_shift, 77);
        do_done();

        // Inputs in idle ignored
        cyc(); check_eq("idle_cyc_phase", phase_shift, 0);
        check_eq("idle_busy", busy, 0);

        // Asynchronous reset mid-ramp
        do_start(8'd10, 8'd40, 8'd10, 8'd1);
        cyc(); check_eq("ar_pre", phase_shift, 20);
        #2 reset_n = 1'b0;
        #1;
        check_eq("ar_phase", phase_shift, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_ramp_done", ramp_done, 0);
        check_eq("ar_halted", halted, 0);
        #3 reset_n = 1'b1;
        tick();
        do_start(8'd10, 8'd40, 8'd10, 8'd1);
        check_eq("ar_restart", phase_shift, 10);
        cyc(); check_eq("ar_restart_step", phase_shift, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
